// File: rtl/comb_job_scheduler_if.sv
// rtl/comb_job_scheduler_if.sv - request, engine and response signal bundle for comb_job_scheduler
//
// Groups the three handshakes around the scheduler:
//   req_*  : (n,m) request stream into the scheduler FIFO (valid/ready)
//   eng_*  : start/done exchange with the combination engine
//   rsp_*  : answered job leaving on a valid/ready port, in request order
//   pending: FIFO occupancy
// Modports:
//   slave  : the scheduler's view
//   master : the environment's view (requester, engine and consumer)
interface comb_job_scheduler_if #(
    parameter int PTR_W = 2,
    parameter int RES_W = 13
) ();
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_n;
    logic [3:0]       req_m;

    logic             eng_start;
    logic [3:0]       eng_n;
    logic [3:0]       eng_m;
    logic             eng_done;
    logic [RES_W-1:0] eng_result;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [3:0]       rsp_n;
    logic [3:0]       rsp_m;
    logic [RES_W-1:0] rsp_result;
    logic             rsp_bypass;

    logic [PTR_W:0]   pending;

    modport slave (
        input  req_valid, req_n, req_m,
        output req_ready,
        output eng_start, eng_n, eng_m,
        input  eng_done, eng_result,
        output rsp_valid, rsp_n, rsp_m, rsp_result, rsp_bypass,
        input  rsp_ready,
        output pending
    );

    modport master (
        output req_valid, req_n, req_m,
        input  req_ready,
        input  eng_start, eng_n, eng_m,
        output eng_done, eng_result,
        input  rsp_valid, rsp_n, rsp_m, rsp_result, rsp_bypass,
        output rsp_ready,
        input  pending
    );
endinterface

// File: rtl/comb_job_scheduler.sv
// rtl/comb_job_scheduler.sv - request FIFO and job sequencer in front of the Comb engine
//
// Buffers (n,m) requests, answers trivial cases (m>n, m==0, m==n) locally and
// hands the rest to the engine one at a time with a single-cycle start pulse.
// Every job, local or engine-resolved, produces exactly one response, in order.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (shared with the engine)
//   bus  : comb_job_scheduler_if.slave
//          req_valid/req_ready/req_n/req_m         request stream
//          eng_start/eng_n/eng_m/eng_done/eng_result engine exchange
//          rsp_valid/rsp_ready/rsp_n/rsp_m/rsp_result/rsp_bypass response stream
//          pending                                 FIFO occupancy
module comb_job_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2,
    parameter int RES_W      = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    comb_job_scheduler_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [RES_W-1:0] ONE_C   = {{(RES_W - 1){1'b0}}, 1'b1};

    logic [3:0]       fifo_n_q [FIFO_DEPTH];
    logic [3:0]       fifo_m_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic             req_ready_w;
    logic             push;
    logic             pop;

    state_t           state_q;
    logic [3:0]       job_n_q;
    logic [3:0]       job_m_q;
    logic             eng_start_q;
    logic             rsp_valid_q;
    logic [RES_W-1:0] rsp_result_q;
    logic             rsp_bypass_q;

    // No pass-through: a full FIFO refuses even if a pop happens this cycle.
    assign req_ready_w = (count_q < DEPTH_C);
    assign push        = bus.req_valid & req_ready_w;
    assign pop         = (state_q == S_IDLE) & (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset: count_q gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_n_q[wr_ptr_q] <= bus.req_n;
            fifo_m_q[wr_ptr_q] <= bus.req_m;
        end
    end

    // Job sequencer. job_n/m double as the engine operands and the response
    // tag, so they stay put from CHECK until the response is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            job_n_q      <= '0;
            job_m_q      <= '0;
            eng_start_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_bypass_q <= 1'b0;
        end else begin
            eng_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        job_n_q <= fifo_n_q[rd_ptr_q];
                        job_m_q <= fifo_m_q[rd_ptr_q];
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (job_m_q > job_n_q) begin
                        rsp_result_q <= '0;
                        rsp_bypass_q <= 1'b1;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= S_RESP;
                    end else if ((job_m_q == 4'd0) || (job_m_q == job_n_q)) begin
                        rsp_result_q <= ONE_C;
                        rsp_bypass_q <= 1'b1;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= S_RESP;
                    end else begin
                        // Registered so the pulse lines up with the ISSUE cycle.
                        eng_start_q <= 1'b1;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.eng_done) begin
                        rsp_result_q <= bus.eng_result;
                        rsp_bypass_q <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_w;
    assign bus.pending    = count_q;
    assign bus.eng_start  = eng_start_q;
    assign bus.eng_n      = job_n_q;
    assign bus.eng_m      = job_m_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_n      = job_n_q;
    assign bus.rsp_m      = job_m_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_bypass = rsp_bypass_q;

endmodule

// File: tb/tb_comb_job_scheduler.sv
// tb/tb_comb_job_scheduler.sv - directed self-checking bench for comb_job_scheduler
module tb_comb_job_scheduler;

    typedef struct packed {
        logic [3:0]  n;
        logic [3:0]  m;
        logic [12:0] r;
        logic        b;
    } rsp_t;

    logic clk;
    logic rst;

    comb_job_scheduler_if bus ();

    comb_job_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic        model_done;
    logic [12:0] model_res;
    logic        spur_done;
    logic [12:0] spur_res;

    assign bus.eng_done   = model_done | spur_done;
    assign bus.eng_result = model_res | spur_res;

    int   total;
    int   bad;
    int   start_cnt;
    int   eng_delay;
    bit   eng_stall;
    rsp_t rsp_q [$];
    rsp_t exp_q [$];

    int t3n [5] = '{7, 8, 6, 12, 14};
    int t3m [5] = '{2, 4, 3, 5, 7};
    int t3r [5] = '{21, 70, 20, 792, 3432};

    int t6n [15] = '{5, 6, 7, 9, 11,   4, 13, 10, 8, 12,   15, 15, 14, 3, 9};
    int t6m [15] = '{2, 2, 3, 4, 5,    1, 6, 5, 2, 3,      1, 14, 4, 2, 2};
    int t6r [15] = '{10, 15, 35, 126, 462,  4, 1716, 252, 28, 220,  15, 15, 1001, 3, 36};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [12:0] binom(input logic [3:0] n, input logic [3:0] m);
        int r;
        r = 1;
        for (int i = 1; i <= int'(m); i++) begin
            r = r * (int'(n) - int'(m) + i) / i;
        end
        return 13'(r);
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Engine model: answers C(n,m) eng_delay cycles after a start pulse,
    // holds off while eng_stall is set, and abandons the job on reset.
    initial begin
        logic [3:0] en;
        logic [3:0] em;
        model_done = 1'b0;
        model_res  = '0;
        start_cnt  = 0;
        forever begin
            @(negedge clk);
            if (!rst && bus.eng_start) begin
                start_cnt++;
                en = bus.eng_n;
                em = bus.eng_m;
                for (int k = 0; k < eng_delay && !rst; k++) @(negedge clk);
                while (eng_stall && !rst) @(negedge clk);
                if (!rst) begin
                    model_done = 1'b1;
                    model_res  = binom(en, em);
                    @(negedge clk);
                    model_done = 1'b0;
                    model_res  = '0;
                end
            end
        end
    end

    // Response collector: records every accepted response.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst && bus.rsp_valid && bus.rsp_ready) begin
                rsp_q.push_back({bus.rsp_n, bus.rsp_m, bus.rsp_result, bus.rsp_bypass});
            end
        end
    end

    task automatic push(input logic [3:0] n, input logic [3:0] m);
        int g;
        bus.req_valid = 1'b1;
        bus.req_n     = n;
        bus.req_m     = m;
        g = 0;
        while (!bus.req_ready && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (g >= 300) check("push_timeout", 32'(g), 32'(0));
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic expect_rsp(input int n, input int m, input int r, input int b);
        exp_q.push_back({4'(n), 4'(m), 13'(r), 1'(b)});
    endtask

    task automatic settle();
        int g;
        rsp_t a;
        rsp_t e;
        g = 0;
        while (rsp_q.size() < exp_q.size() && g < 2000) begin
            @(negedge clk);
            g++;
        end
        check("rsp_count", 32'(rsp_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && rsp_q.size() > 0) begin
            a = rsp_q.pop_front();
            e = exp_q.pop_front();
            check("rsp", 32'(a), 32'(e));
        end
        exp_q.delete();
        rsp_q.delete();
        @(negedge clk);
    endtask

    initial begin
        int   s;
        int   sz;
        int   g;
        bit   stable;
        rsp_t h;

        total         = 0;
        bad           = 0;
        eng_delay     = 20;
        eng_stall     = 1'b0;
        spur_done     = 1'b0;
        spur_res      = '0;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_n     = '0;
        bus.req_m     = '0;
        bus.rsp_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'(1));
        check("rst_pending", 32'(bus.pending), 32'(0));
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
        check("rst_eng_start", 32'(bus.eng_start), 32'(0));
        check("rst_rsp_result", 32'(bus.rsp_result), 32'(0));
        check("rst_rsp_bypass", 32'(bus.rsp_bypass), 32'(0));
        rst = 1'b0;
        @(negedge clk);

        // 1: engine job, start pulse at t+3, answer 20 cycles later
        push(4'd10, 4'd3);
        @(negedge clk);
        check("t1_start_t2", 32'(bus.eng_start), 32'(0));
        @(negedge clk);
        check("t1_start_t3", 32'(bus.eng_start), 32'(1));
        check("t1_eng_n", 32'(bus.eng_n), 32'(10));
        check("t1_eng_m", 32'(bus.eng_m), 32'(3));
        @(negedge clk);
        check("t1_start_t4", 32'(bus.eng_start), 32'(0));
        expect_rsp(10, 3, 120, 0);
        settle();
        check("t1_starts", 32'(start_cnt), 32'(1));

        // 2: local answers, first one visible at t+3
        eng_delay = 3;
        push(4'd5, 4'd7);
        @(negedge clk);
        check("t2_valid_t2", 32'(bus.rsp_valid), 32'(0));
        @(negedge clk);
        check("t2_valid_t3", 32'(bus.rsp_valid), 32'(1));
        push(4'd6, 4'd0);
        push(4'd9, 4'd9);
        expect_rsp(5, 7, 0, 1);
        expect_rsp(6, 0, 1, 1);
        expect_rsp(9, 9, 1, 1);
        settle();
        check("t2_starts", 32'(start_cnt), 32'(1));

        // 3: five pushes behind a stalled engine fill the FIFO
        eng_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push(4'(t3n[i]), 4'(t3m[i]));
            expect_rsp(t3n[i], t3m[i], t3r[i], 0);
        end
        check("t3_pending_full", 32'(bus.pending), 32'(4));
        check("t3_ready_full", 32'(bus.req_ready), 32'(0));
        bus.req_valid = 1'b1;
        bus.req_n     = 4'd1;
        bus.req_m     = 4'd1;
        repeat (3) @(negedge clk);
        bus.req_valid = 1'b0;
        check("t3_no_push_full", 32'(bus.pending), 32'(4));
        eng_stall = 1'b0;
        settle();
        check("t3_pending_empty", 32'(bus.pending), 32'(0));

        // 4: response held back for 10 cycles
        bus.rsp_ready = 1'b0;
        push(4'd15, 4'd7);
        push(4'd4, 4'd2);
        g = 0;
        while (!bus.rsp_valid && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("t4_valid", 32'(bus.rsp_valid), 32'(1));
        check("t4_result", 32'(bus.rsp_result), 32'(6435));
        check("t4_bypass", 32'(bus.rsp_bypass), 32'(0));
        h      = {bus.rsp_n, bus.rsp_m, bus.rsp_result, bus.rsp_bypass};
        s      = start_cnt;
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if ({bus.rsp_n, bus.rsp_m, bus.rsp_result, bus.rsp_bypass} != h || !bus.rsp_valid)
                stable = 1'b0;
        end
        check("t4_hold_stable", 32'(stable), 32'(1));
        check("t4_no_start", 32'(start_cnt), 32'(s));
        bus.rsp_ready = 1'b1;
        expect_rsp(15, 7, 6435, 0);
        expect_rsp(4, 2, 6, 0);
        settle();
        check("t4_next_start", 32'(start_cnt), 32'(s + 1));

        // 5a: spurious done in IDLE
        sz        = rsp_q.size();
        spur_done = 1'b1;
        spur_res  = 13'd99;
        @(negedge clk);
        spur_done = 1'b0;
        spur_res  = '0;
        repeat (5) @(negedge clk);
        check("t5_idle_valid", 32'(bus.rsp_valid), 32'(0));
        check("t5_idle_norsp", 32'(rsp_q.size()), 32'(sz));

        // 5b: spurious done while a response is waiting
        bus.rsp_ready = 1'b0;
        push(4'd3, 4'd3);
        g = 0;
        while (!bus.rsp_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        spur_done = 1'b1;
        spur_res  = 13'd77;
        @(negedge clk);
        spur_done = 1'b0;
        spur_res  = '0;
        @(negedge clk);
        check("t5_resp_result", 32'(bus.rsp_result), 32'(1));
        check("t5_resp_bypass", 32'(bus.rsp_bypass), 32'(1));
        bus.rsp_ready = 1'b1;
        expect_rsp(3, 3, 1, 1);
        settle();

        // 5c: reset while waiting on the engine
        eng_stall = 1'b1;
        push(4'd8, 4'd3);
        push(4'd5, 4'd2);
        repeat (4) @(negedge clk);
        check("t5_pending_wait", 32'(bus.pending), 32'(1));
        s   = start_cnt;
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_pending", 32'(bus.pending), 32'(0));
        check("t5_rst_valid", 32'(bus.rsp_valid), 32'(0));
        check("t5_rst_start", 32'(bus.eng_start), 32'(0));
        check("t5_rst_ready", 32'(bus.req_ready), 32'(1));
        @(negedge clk);
        rst       = 1'b0;
        eng_stall = 1'b0;
        sz        = rsp_q.size();
        repeat (30) @(negedge clk);
        check("t5_rst_norsp", 32'(rsp_q.size()), 32'(sz));
        check("t5_rst_nostart", 32'(start_cnt), 32'(s));

        // 6: fill and drain three times, pointers wrap
        eng_delay = 1;
        for (int r = 0; r < 3; r++) begin
            eng_stall = 1'b1;
            for (int i = 0; i < 5; i++) begin
                push(4'(t6n[r*5+i]), 4'(t6m[r*5+i]));
                expect_rsp(t6n[r*5+i], t6m[r*5+i], t6r[r*5+i], 0);
            end
            check("t6_pending_full", 32'(bus.pending), 32'(4));
            eng_stall = 1'b0;
            settle();
            check("t6_pending_empty", 32'(bus.pending), 32'(0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
